// File: rtl/serial_bus_pkg.sv
// -----------------------------------------------------------------------------
// serial_bus_pkg
// Shared types and constants for the two-master serial bus arbiter.
//   arb_state_t        : arbiter FSM states (IDLE, OWN_M1, OWN_M2, GAP)
//   M1_ID / M2_ID      : master id encoding used by resume_master and last-owner
//   DEFAULT_GAP_CYCLES : default handover gap between owners
//   DEFAULT_GAP_W      : default gap counter width
// -----------------------------------------------------------------------------
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  localparam logic M1_ID = 1'b0;
  localparam logic M2_ID = 1'b1;

  localparam int DEFAULT_GAP_CYCLES = 1;
  localparam int DEFAULT_GAP_W      = 4;

endpackage

// File: rtl/arb_gap_timer.sv
// -----------------------------------------------------------------------------
// arb_gap_timer
// Loadable down-counter that times the idle gap between two bus owners.
// The count saturates at zero; o_zero is a plain decode of the count register.
// Ports:
//   i_clock    : system clock
//   i_rst      : synchronous reset, active-high (count -> 0)
//   i_load     : load i_load_val this cycle (takes precedence over counting)
//   i_load_val : value loaded on i_load
//   o_zero     : count register is zero
// -----------------------------------------------------------------------------
module arb_gap_timer
  import serial_bus_pkg::*;
#(
  parameter int GAP_W = DEFAULT_GAP_W
) (
  input  logic             i_clock,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [GAP_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/serial_bus_arbiter.sv
// -----------------------------------------------------------------------------
// serial_bus_arbiter
// Arbitrates the shared serial bus between master 1 and master 2, enforces an
// idle gap between owners and supports split transactions (park / resume).
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority between the
// two masters for ordinary (non-resume) requests; otherwise m1 beats m2.
//
// Handshake: a master raises mX_req and holds it for the whole transaction;
// mX_grant rises one edge after the request is sampled in IDLE and stays high
// until the master drops mX_req (release) or the slave pulses bus_split
// (park). A parked master keeps its req high and is only eligible again once
// a split_resume for it has been seen; dropping req while parked aborts.
//
// Ports:
//   clock, rst          : clock and synchronous active-high reset
//   m1_req, m2_req      : bus requests
//   bus_split           : owner's transaction is split (pulse)
//   split_resume        : a split transaction may complete (pulse)
//   resume_master       : master id for split_resume (0 = m1, 1 = m2)
//   m1_grant, m2_grant  : registered exclusive grants
//   split_parked        : per-master parked flags, bit0 = m1
//   arb_busy            : FSM is not in IDLE
// -----------------------------------------------------------------------------
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int GAP_W      = DEFAULT_GAP_W
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       bus_split,
  input  logic       split_resume,
  input  logic       resume_master,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] split_parked,
  output logic       arb_busy
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic [1:0] r_parked;
  logic [1:0] r_pending;
  logic       r_m1_grant;
  logic       r_m2_grant;
  logic       r_busy;

  logic [1:0] w_req;
  logic [1:0] w_elig;
  logic [1:0] w_resume_req;
  logic       w_win_valid;
  logic       w_win_id;
  logic [1:0] w_split_park;
  logic [1:0] w_grant_now;
  logic [1:0] w_resume_hit;
  logic       w_gap_load;
  logic       w_gap_zero;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;
`endif

  assign w_req        = {m2_req, m1_req};
  // A parked master is only eligible once its resume is pending.
  assign w_elig       = w_req & (~r_parked | r_pending);
  assign w_resume_req = w_req & r_pending;

  // Winner selection used only when the FSM sits in IDLE.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = M1_ID;
    if (w_resume_req[0]) begin
      w_win_valid = 1'b1;
      w_win_id    = M1_ID;
    end else if (w_resume_req[1]) begin
      w_win_valid = 1'b1;
      w_win_id    = M2_ID;
    end else if (w_elig == 2'b11) begin
      w_win_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      w_win_id    = ~r_last_owner;
`else
      w_win_id    = M1_ID;
`endif
    end else if (w_elig[0]) begin
      w_win_valid = 1'b1;
      w_win_id    = M1_ID;
    end else if (w_elig[1]) begin
      w_win_valid = 1'b1;
      w_win_id    = M2_ID;
    end
  end

  // Next-state logic. A split in the same cycle as a req drop both lead to GAP;
  // the parked flag below is what distinguishes them.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_next_state = (w_win_id == M1_ID) ? OWN_M1 : OWN_M2;
        end
      end
      OWN_M1: if (bus_split || !m1_req) w_next_state = GAP;
      OWN_M2: if (bus_split || !m2_req) w_next_state = GAP;
      GAP:    if (w_gap_zero) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_gap_load   = (w_next_state == GAP) && (r_state != GAP);
  assign w_split_park = bus_split ? {r_state == OWN_M2, r_state == OWN_M1} : 2'b00;
  assign w_grant_now  = (r_state == IDLE && w_win_valid) ?
                        ((w_win_id == M2_ID) ? 2'b10 : 2'b01) : 2'b00;
  // Resume only counts for a master that is already parked.
  assign w_resume_hit = split_resume ?
                        (r_parked & ((resume_master == M2_ID) ? 2'b10 : 2'b01)) : 2'b00;

  arb_gap_timer #(
    .GAP_W(GAP_W)
  ) u_gap_timer (
    .i_clock    (clock),
    .i_rst      (rst),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= IDLE;
      r_m1_grant <= 1'b0;
      r_m2_grant <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_m1_grant <= (w_next_state == OWN_M1);
      r_m2_grant <= (w_next_state == OWN_M2);
      r_busy     <= (w_next_state != IDLE);
    end
  end

  // Park/pending bookkeeping per master: split, then grant/abort, then resume.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_parked  <= 2'b00;
      r_pending <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_split_park[i]) begin
          r_parked[i]  <= 1'b1;
          r_pending[i] <= 1'b0;
        end else if (w_grant_now[i] || (r_parked[i] && !w_req[i])) begin
          r_parked[i]  <= 1'b0;
          r_pending[i] <= 1'b0;
        end else if (w_resume_hit[i]) begin
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      r_last_owner <= M2_ID;
    end else if (r_state == IDLE && w_win_valid) begin
      r_last_owner <= w_win_id;
    end
  end
`endif

  assign m1_grant     = r_m1_grant;
  assign m2_grant     = r_m2_grant;
  assign split_parked = r_parked;
  assign arb_busy     = r_busy;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_bus_arbiter
// Directed scenarios for reset, handover, priority, split/resume and reset
// during a transaction, followed by randomized traffic compared against a
// timestamp-based model of bus ownership.
// -----------------------------------------------------------------------------
module tb_serial_bus_arbiter;

  localparam int GAP = 3;

  logic       clock;
  logic       rst;
  logic       m1_req;
  logic       m2_req;
  logic       bus_split;
  logic       split_resume;
  logic       resume_master;
  logic       m1_grant;
  logic       m2_grant;
  logic [1:0] split_parked;
  logic       arb_busy;

  int checks = 0;
  int errors = 0;

  serial_bus_arbiter #(
    .GAP_CYCLES (GAP),
    .GAP_W      (4)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .m1_req        (m1_req),
    .m2_req        (m2_req),
    .bus_split     (bus_split),
    .split_resume  (split_resume),
    .resume_master (resume_master),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .split_parked  (split_parked),
    .arb_busy      (arb_busy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Ownership is tracked as "who owns" plus the earliest edge number at which
  // a new grant may be issued (release edge + GAP + 1).
  int       ecyc = 0;
  int       mo = 0;            // 0 none, 1 m1, 2 m2
  int       free_at = 0;
  bit [1:0] mp = 2'b00;        // parked
  bit [1:0] mq = 2'b00;        // resume pending
  bit       mlast = 1'b1;      // last owner id (1 = m2)
  bit       last_rst = 1'b1;

  task automatic model_step();
    bit [1:0] rq, p0, q0, touched, hit, elig;
    int win;
    ecyc = ecyc + 1;
    last_rst = rst;
    if (rst) begin
      mo = 0; mp = 2'b00; mq = 2'b00; free_at = 0; mlast = 1'b1;
    end else begin
      rq = {m2_req, m1_req};
      p0 = mp;
      q0 = mq;
      touched = 2'b00;
      hit = 2'b00;
      if (split_resume) hit[resume_master] = p0[resume_master];
      if (mo != 0) begin
        if (bus_split) begin
          mp[mo-1] = 1'b1; mq[mo-1] = 1'b0; touched[mo-1] = 1'b1;
          mo = 0; free_at = ecyc + GAP + 1;
        end else if (!rq[mo-1]) begin
          mo = 0; free_at = ecyc + GAP + 1;
        end
      end else if (ecyc >= free_at) begin
        elig = rq & (~p0 | q0);
        win = 0;
        if (rq[0] && q0[0]) win = 1;
        else if (rq[1] && q0[1]) win = 2;
        else if (elig == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
          win = mlast ? 1 : 2;
`else
          win = 1;
`endif
        end
        else if (elig[0]) win = 1;
        else if (elig[1]) win = 2;
        if (win != 0) begin
          mo = win; mp[win-1] = 1'b0; mq[win-1] = 1'b0; touched[win-1] = 1'b1;
          mlast = (win == 2);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!touched[i]) begin
          if (p0[i] && !rq[i]) begin mp[i] = 1'b0; mq[i] = 1'b0; end
          else if (hit[i]) mq[i] = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- invariant monitor ----------------
  int ncyc = 0;
  int fall1 = -100;
  int fall2 = -100;
  bit pg1 = 1'b0;
  bit pg2 = 1'b0;

  initial forever begin
    @(negedge clock);
    ncyc = ncyc + 1;
    if (last_rst) begin
      fall1 = -100; fall2 = -100;
    end else begin
      checks++;
      if (m1_grant && m2_grant) begin
        errors++;
        $display("FAIL grant_overlap m1_grant=%0b m2_grant=%0b exp=not both 1", m1_grant, m2_grant);
      end
      if (pg1 && !m1_grant) fall1 = ncyc;
      if (pg2 && !m2_grant) fall2 = ncyc;
      if (!pg1 && m1_grant) begin
        checks++;
        if (ncyc - fall2 < GAP + 1) begin
          errors++;
          $display("FAIL gap_m1 edges_since_m2_fall=%0d exp>=%0d", ncyc - fall2, GAP + 1);
        end
      end
      if (!pg2 && m2_grant) begin
        checks++;
        if (ncyc - fall1 < GAP + 1) begin
          errors++;
          $display("FAIL gap_m2 edges_since_m1_fall=%0d exp>=%0d", ncyc - fall1, GAP + 1);
        end
      end
    end
    pg1 = m1_grant;
    pg2 = m2_grant;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; m1_req = 1'b1; m2_req = 1'b1;
    repeat (10) tick();
    checks++; if (m1_grant !== 1'b0) begin errors++; $display("FAIL reset_m1_grant got=%0b exp=0", m1_grant); end
    checks++; if (m2_grant !== 1'b0) begin errors++; $display("FAIL reset_m2_grant got=%0b exp=0", m2_grant); end
    checks++; if (split_parked !== 2'b00) begin errors++; $display("FAIL reset_parked got=%b exp=00", split_parked); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", arb_busy); end
    rst = 1'b0;
    tick();
    checks++; if (m1_grant !== 1'b1) begin errors++; $display("FAIL first_grant_m1 got=%0b exp=1", m1_grant); end
    checks++; if (m2_grant !== 1'b0) begin errors++; $display("FAIL first_grant_m2 got=%0b exp=0", m2_grant); end
  endtask

  task automatic test_handover();
    int n;
    m1_req = 1'b0;
    tick();
    checks++; if (m1_grant !== 1'b0) begin errors++; $display("FAIL handover_m1_fall got=%0b exp=0", m1_grant); end
    n = 0;
    while (!m2_grant && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n != GAP + 1) begin errors++; $display("FAIL handover_latency got=%0d exp=%0d", n, GAP + 1); end
    m2_req = 1'b0;
    tick();
    repeat (GAP) tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL handover_idle busy=%0b exp=0", arb_busy); end
  endtask

  task automatic test_back_to_back();
    int exp_win[3];
`ifdef ARB_ROUND_ROBIN_EN
    exp_win = '{1, 2, 1};
`else
    exp_win = '{1, 1, 1};
`endif
    for (int r = 0; r < 3; r++) begin
      m1_req = 1'b1; m2_req = 1'b1;
      tick();
      checks++;
      if (m1_grant !== (exp_win[r] == 1) || m2_grant !== (exp_win[r] == 2)) begin
        errors++;
        $display("FAIL b2b_round%0d grants m1=%0b m2=%0b exp_winner=m%0d", r, m1_grant, m2_grant, exp_win[r]);
      end
      m1_req = 1'b0; m2_req = 1'b0;
      tick();
      repeat (GAP) tick();
    end
  endtask

  task automatic test_split_resume();
    m1_req = 1'b1;
    tick();
    m2_req = 1'b1; bus_split = 1'b1;
    tick();
    bus_split = 1'b0;
    checks++; if (m1_grant !== 1'b0) begin errors++; $display("FAIL split_m1_drop got=%0b exp=0", m1_grant); end
    checks++; if (split_parked !== 2'b01) begin errors++; $display("FAIL split_parked got=%b exp=01", split_parked); end
    repeat (GAP) tick();
    checks++; if (m2_grant !== 1'b0) begin errors++; $display("FAIL split_gap_m2 got=%0b exp=0", m2_grant); end
    tick();
    checks++; if (m2_grant !== 1'b1 || m1_grant !== 1'b0) begin errors++; $display("FAIL split_lend m1=%0b m2=%0b exp m1=0 m2=1", m1_grant, m2_grant); end
    split_resume = 1'b1; resume_master = 1'b0;
    tick();
    split_resume = 1'b0;
    checks++; if (m2_grant !== 1'b1 || split_parked !== 2'b01) begin errors++; $display("FAIL resume_no_preempt m2=%0b parked=%b exp m2=1 parked=01", m2_grant, split_parked); end
    m2_req = 1'b0;
    tick();
    repeat (GAP) tick();
    tick();
    checks++; if (m1_grant !== 1'b1) begin errors++; $display("FAIL resume_regrant got=%0b exp=1", m1_grant); end
    checks++; if (split_parked !== 2'b00) begin errors++; $display("FAIL resume_unpark got=%b exp=00", split_parked); end
    m1_req = 1'b0;
    tick();
    repeat (GAP) tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL split_idle busy=%0b exp=0", arb_busy); end
  endtask

  task automatic test_double_park();
    m1_req = 1'b1;
    tick();
    m2_req = 1'b1; bus_split = 1'b1;
    tick();
    bus_split = 1'b0;
    repeat (GAP + 1) tick();
    checks++; if (m2_grant !== 1'b1) begin errors++; $display("FAIL dpark_m2_owns got=%0b exp=1", m2_grant); end
    bus_split = 1'b1;
    tick();
    bus_split = 1'b0;
    repeat (GAP + 3) tick();
    checks++; if (split_parked !== 2'b11) begin errors++; $display("FAIL dpark_both got=%b exp=11", split_parked); end
    checks++; if (arb_busy !== 1'b0 || m1_grant !== 1'b0 || m2_grant !== 1'b0) begin errors++; $display("FAIL dpark_idle busy=%0b m1=%0b m2=%0b exp all 0", arb_busy, m1_grant, m2_grant); end
    split_resume = 1'b1; resume_master = 1'b1;
    tick();
    split_resume = 1'b0;
    tick();
    checks++; if (m2_grant !== 1'b1 || m1_grant !== 1'b0) begin errors++; $display("FAIL dpark_resume_m2 m1=%0b m2=%0b exp m1=0 m2=1", m1_grant, m2_grant); end
    checks++; if (split_parked !== 2'b01) begin errors++; $display("FAIL dpark_m1_still got=%b exp=01", split_parked); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    checks++; if (m1_grant !== 1'b0 || m2_grant !== 1'b0) begin errors++; $display("FAIL rstmid_grants m1=%0b m2=%0b exp 0 0", m1_grant, m2_grant); end
    checks++; if (split_parked !== 2'b00) begin errors++; $display("FAIL rstmid_parked got=%b exp=00", split_parked); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", arb_busy); end
    rst = 1'b0; m1_req = 1'b0; m2_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 9) == 0) m1_req = ~m1_req;
      if ($urandom_range(0, 9) == 0) m2_req = ~m2_req;
      bus_split     = ($urandom_range(0, 5) == 0);
      split_resume  = ($urandom_range(0, 4) == 0);
      resume_master = 1'($urandom_range(0, 1));
      tick();
      checks++; if (m1_grant !== (mo == 1)) begin errors++; $display("FAIL rand_m1_grant cyc=%0d got=%0b exp=%0b", c, m1_grant, mo == 1); end
      checks++; if (m2_grant !== (mo == 2)) begin errors++; $display("FAIL rand_m2_grant cyc=%0d got=%0b exp=%0b", c, m2_grant, mo == 2); end
      checks++; if (split_parked !== mp) begin errors++; $display("FAIL rand_parked cyc=%0d got=%b exp=%b", c, split_parked, mp); end
      checks++; if (arb_busy !== ((mo != 0) || (ecyc < free_at - 1))) begin errors++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", c, arb_busy, (mo != 0) || (ecyc < free_at - 1)); end
    end
    rst = 1'b0; bus_split = 1'b0; split_resume = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
    bus_split = 1'b0; split_resume = 1'b0; resume_master = 1'b0;
    test_reset();
    test_handover();
    test_back_to_back();
    test_split_resume();
    test_double_park();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog time=%0t exp=finish earlier", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
